// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Results are held in output registers until the next operation completes.
module serial_subtractor #(
    parameter int unsigned WIDTH = 3
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;

    logic             d_bit, br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_shift = {d_bit, res_q[WIDTH-1:1]};

        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the result; earlier edges leave the outputs alone.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_shift;
                    borrow_d = br_next;
                    ovf_d    = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) & ~rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepts push a model result, consumed outputs pop it.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = -1;
    int   done_cnt = 0;
    bit   b2b = 1'b0;
    logic ov_prev = 1'b0;
    logic [4:0] exp_q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packed as {diff, borrow, overflow}.
    function automatic logic [4:0] model(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] d;
        d = 3'(a - b);
        return {d, (a < b), ((a[2] != b[2]) && (d[2] != a[2]))};
    endfunction

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) check_eq("latency", cyc - last_acc, WIDTH);
            if (bus.in_valid && bus.in_ready) begin
                if (b2b && last_acc >= 0) check_eq("accept_gap", cyc + 1 - last_acc, WIDTH + 2);
                last_acc = cyc + 1;
                exp_q.push_back(model(bus.a, bus.b));
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("scoreboard_depth", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("diff", bus.diff, e[4:2]);
                    check_eq("borrow", bus.borrow, e[1]);
                    check_eq("overflow", bus.overflow, e[0]);
                end
                done_cnt++;
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [2:0] a, input logic [2:0] b);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 3'($urandom);
        bus.b = 3'($urandom);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("busy_in_ready", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("done_timeout", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] a, input logic [2:0] b);
        send(a, b);
        wait_done();
    endtask

    initial begin
        logic [4:0] e;
        int         start;
        bit         ok;
        bit         seen;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_diff", bus.diff, 0);
        check_eq("rst_borrow", bus.borrow, 0);
        check_eq("rst_overflow", bus.overflow, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", bus.in_ready, 1);

        // Basic and directed borrow/overflow cases.
        run_op(3'd5, 3'd3);
        run_op(3'd3, 3'd5);
        run_op(3'd3, 3'd4);
        run_op(3'd4, 3'd1);
        run_op(3'd0, 3'd0);
        check_eq("directed_results", done_cnt, 5);

        // Backpressure: result must hold while inputs churn.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(3'd6, 3'd3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("bp_valid_timeout", ok, 1);
        e = model(3'd6, 3'd3);
        start = done_cnt;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = ~bus.in_valid;
            bus.a = 3'($urandom);
            bus.b = 3'($urandom);
            @(negedge clk);
            check_eq("bp_out_valid", bus.out_valid, 1);
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_diff", bus.diff, e[4:2]);
            check_eq("bp_borrow", bus.borrow, e[1]);
            check_eq("bp_overflow", bus.overflow, e[0]);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("bp_consumed_once", done_cnt - start, 1);
        check_eq("bp_out_valid_low", bus.out_valid, 0);

        // Reset on the second SHIFT edge aborts the operation.
        send(3'd7, 3'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_out_valid", bus.out_valid, 0);
        check_eq("abort_diff", bus.diff, 0);
        check_eq("abort_borrow", bus.borrow, 0);
        check_eq("abort_overflow", bus.overflow, 0);
        check_eq("abort_in_ready", bus.in_ready, 1);
        seen = 1'b0;
        start = done_cnt;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check_eq("abort_no_pulse", seen, 0);
        check_eq("abort_no_result", done_cnt - start, 0);
        run_op(3'd6, 3'd2);

        // Back-to-back sweep of every operand pair.
        @(posedge clk);
        #1;
        start = done_cnt;
        last_acc = -1;
        b2b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.a = 3'(i >> 3);
            bus.b = 3'(i);
            bus.in_valid = 1'b1;
            ok = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_eq("b2b_accept_timeout", ok, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_cnt - start >= 64) break;
        end
        @(posedge clk);
        #1;
        check_eq("b2b_results", done_cnt - start, 64);
        check_eq("b2b_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
